// File: rtl/reg_move_controller.sv
// reg_move_controller: sequences LOAD/MOVE/READ/SWAP commands onto a single-port register bank.
//   clk, rst_n             : clock, asynchronous active-low reset
//   cmd_valid/ready        : command handshake; cmd_op/dst/src/imm latched on accept
//   rsp_valid/ready        : response handshake; rsp_data holds the result while in RESP
//   busy                   : high whenever a command is in flight
//   bank_reg_sel/data_in/en: register bank select, write data and write enable
//   bank_data_out          : combinational read data of bank_reg_sel
module reg_move_controller #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_dst,
    input  logic [SEL_W-1:0]  cmd_src,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [SEL_W-1:0]  bank_reg_sel,
    output logic [DATA_W-1:0] bank_data_in,
    output logic              bank_en,
    input  logic [DATA_W-1:0] bank_data_out
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_WR_A = 3'd3;
    localparam logic [2:0] S_WR_B = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b11;
    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [1:0]        r_op;
    logic [SEL_W-1:0]  r_dst;
    logic [SEL_W-1:0]  r_src;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_ta;
    logic [DATA_W-1:0] r_tb;
    logic              r_ready;
    logic              w_acc;
    // r_ready keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = r_ready && (r_state == S_IDLE);
    assign w_acc     = cmd_valid && cmd_ready;
    always_comb begin
        w_next = (r_state == S_IDLE) ? (w_acc ? ((cmd_op == OP_LOAD) ? S_WR_A : S_RD_A) : S_IDLE) :
                 (r_state == S_RD_A) ? ((r_op == OP_MOVE) ? S_WR_A : (r_op == OP_SWAP) ? S_RD_B : S_RESP) :
                 (r_state == S_RD_B) ? S_WR_A :
                 (r_state == S_WR_A) ? ((r_op == OP_SWAP) ? S_WR_B : S_RESP) :
                 (r_state == S_WR_B) ? S_RESP :
                 (r_state == S_RESP) ? (rsp_ready ? S_IDLE : S_RESP) :
                 S_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_op    <= '0;
            r_dst   <= '0;
            r_src   <= '0;
            r_imm   <= '0;
            r_ta    <= '0;
            r_tb    <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= 1'b1;
            if (w_acc) begin
                r_op  <= cmd_op;
                r_dst <= cmd_dst;
                r_src <= cmd_src;
                r_imm <= cmd_imm;
            end
            if (r_state == S_RD_A) r_ta <= bank_data_out;
            if (r_state == S_RD_B) r_tb <= bank_data_out;
        end
    end
    assign busy         = (r_state != S_IDLE);
    assign rsp_valid    = (r_state == S_RESP);
    // temp A holds the source value for MOVE, READ and SWAP alike
    assign rsp_data     = (r_state == S_RESP) ? ((r_op == OP_LOAD) ? r_imm : r_ta) : '0;
    assign bank_en      = (r_state == S_WR_A) || (r_state == S_WR_B);
    assign bank_reg_sel = ((r_state == S_RD_A) || (r_state == S_WR_B)) ? r_src :
                          ((r_state == S_RD_B) || (r_state == S_WR_A)) ? r_dst : '0;
    assign bank_data_in = (r_state == S_WR_A) ? ((r_op == OP_LOAD) ? r_imm : r_ta) :
                          (r_state == S_WR_B) ? r_tb : '0;
endmodule

// File: tb/tb_reg_move_controller.sv
// tb_reg_move_controller: directed and random commands against an 8x8 bank and a reference model.
module tb_reg_move_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [2:0] cmd_dst = '0;
    logic [2:0] cmd_src = '0;
    logic [7:0] cmd_imm = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       busy;
    logic [2:0] bank_reg_sel;
    logic [7:0] bank_data_in;
    logic       bank_en;
    logic [7:0] bank_data_out;
    logic [7:0]  bank [8];
    logic [7:0]  rb [8];
    logic [10:0] wq [$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_move_controller #(.DATA_W(8), .SEL_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .bank_reg_sel(bank_reg_sel), .bank_data_in(bank_data_in),
        .bank_en(bank_en), .bank_data_out(bank_data_out)
    );

    assign bank_data_out = bank[bank_reg_sel];
    always @(posedge clk) begin
        if (bank_en) begin
            bank[bank_reg_sel] <= bank_data_in;
            wq.push_back({bank_reg_sel, bank_data_in});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op);
        return (op == 2'b00) ? 2 : (op == 2'b01) ? 3 : (op == 2'b10) ? 2 : 5;
    endfunction

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic run(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [7:0] imm, input int hold);
        logic [10:0] ew [$];
        logic [7:0]  er;
        int lat = 0;
        er = (op == 2'b00) ? imm : rb[src];
        if (op == 2'b00) ew.push_back({dst, imm});
        if (op == 2'b01) ew.push_back({dst, rb[src]});
        if (op == 2'b11) begin
            ew.push_back({dst, rb[src]});
            ew.push_back({src, rb[dst]});
        end
        wait_ready();
        wq.delete();
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_dst = dst;
        cmd_src = src;
        cmd_imm = imm;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                cmd_valid = 1'b0;
                cmd_op = 2'($urandom);
                cmd_dst = 3'($urandom);
                cmd_src = 3'($urandom);
                cmd_imm = 8'($urandom);
            end
            rsp_ready = rsp_valid ? 1'b0 : 1'($urandom);
        end while (!rsp_valid && lat < 10);
        chk("latency", lat, exp_lat(op));
        chk("rsp_data", rsp_data, er);
        chk("busy_resp", busy, 1);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, er);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_after", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("busy_after", busy, 0);
        chk("write_count", wq.size(), ew.size());
        for (int i = 0; i < ew.size() && i < wq.size(); i++) chk("write_sel_data", wq[i], ew[i]);
        foreach (ew[i]) rb[ew[i][10:8]] = ew[i][7:0];
    endtask

    initial begin
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bank_en", bank_en, 0);
        chk("rst_bank_sel", bank_reg_sel, 0);
        chk("rst_bank_din", bank_data_in, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_ready_pre_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("release_ready_post_edge", cmd_ready, 1);
        for (int i = 0; i < 8; i++) run(2'b00, 3'(i), 3'd0, 8'($urandom), 0);
        run(2'b00, 3'd0, 3'd0, 8'hAA, 0);
        run(2'b00, 3'd3, 3'd0, 8'h55, 0);
        run(2'b10, 3'd0, 3'd0, 8'h00, 0);
        run(2'b10, 3'd0, 3'd3, 8'h00, 0);
        run(2'b01, 3'd7, 3'd3, 8'h00, 4);
        run(2'b10, 3'd0, 3'd7, 8'h00, 0);
        run(2'b00, 3'd1, 3'd0, 8'h12, 0);
        run(2'b00, 3'd2, 3'd0, 8'h34, 0);
        run(2'b11, 3'd2, 3'd1, 8'h00, 0);
        run(2'b10, 3'd0, 3'd1, 8'h00, 0);
        run(2'b10, 3'd0, 3'd2, 8'h00, 0);
        run(2'b00, 3'd5, 3'd0, 8'h9C, 0);
        run(2'b11, 3'd5, 3'd5, 8'h00, 1);
        run(2'b01, 3'd5, 3'd5, 8'h00, 0);
        run(2'b00, 3'd4, 3'd0, 8'h11, 0);
        run(2'b00, 3'd6, 3'd0, 8'h22, 0);
        wait_ready();
        wq.delete();
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        cmd_dst = 3'd6;
        cmd_src = 3'd4;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("wrb_en", bank_en, 1);
        chk("wrb_sel", bank_reg_sel, 3'd4);
        chk("wrb_data", bank_data_in, 8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cmd_ready", cmd_ready, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_bank_en", bank_en, 0);
        chk("arst_bank_sel", bank_reg_sel, 0);
        chk("arst_bank_din", bank_data_in, 0);
        repeat (2) @(negedge clk);
        chk("arst_hold_ready", cmd_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("arst_release_pre_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("arst_release_post_edge", cmd_ready, 1);
        chk("arst_write_count", wq.size(), 1);
        if (wq.size() > 0) chk("arst_write_dst", wq[0], {3'd6, 8'h11});
        rb[6] = 8'h11;
        run(2'b10, 3'd0, 3'd6, 8'h00, 0);
        run(2'b10, 3'd0, 3'd4, 8'h00, 0);
        for (int i = 0; i < 40; i++)
            run(2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), $urandom_range(2));
        for (int i = 0; i < 8; i++) run(2'b10, 3'd0, 3'(i), 8'h00, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_move_controller.md
REG_MOVE_CONTROLLER -- requirements
Module: reg_move_controller

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, register data width; SEL_W, 3, register select width (2**SEL_W registers).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be as follows (clock and reset first):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when valid && ready at clk edge
- cmd_op  input  2  00 LOAD, 01 MOVE, 10 READ, 11 SWAP
- cmd_dst  input  SEL_W  destination register
- cmd_src  input  SEL_W  source register
- cmd_imm  input  DATA_W  immediate for LOAD
- rsp_valid  output  1  result available
- rsp_ready  input  1  result consumed when valid && ready at clk edge
- rsp_data  output  DATA_W  result value
- busy  output  1  high in every state except IDLE
- bank_reg_sel  output  SEL_W  to register_bank reg_sel
- bank_data_in  output  DATA_W  to register_bank data_in
- bank_en  output  1  to register_bank en (write enable)
- bank_data_out  input  DATA_W  from register_bank data_out; combinational read of bank_reg_sel

Function
REQ-004 FSM states SHALL be IDLE, RD_A, RD_B, WR_A, WR_B, RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE; on accept, cmd_op/dst/src/imm SHALL be latched internally, and later cmd_* changes SHALL have no effect.
REQ-006 Transitions after accept SHALL be: LOAD IDLE->WR_A->RESP; MOVE IDLE->RD_A->WR_A->RESP; READ IDLE->RD_A->RESP; SWAP IDLE->RD_A->RD_B->WR_A->WR_B->RESP.
REQ-007 RD_A SHALL drive bank_reg_sel=src, bank_en=0, and capture bank_data_out into temp A at the exiting edge.
REQ-008 RD_B SHALL drive bank_reg_sel=dst, bank_en=0, and capture bank_data_out into temp B at the exiting edge.
REQ-009 WR_A SHALL drive bank_en=1, bank_reg_sel=dst, bank_data_in=imm for LOAD or temp A for MOVE/SWAP.
REQ-010 WR_B SHALL drive bank_en=1, bank_reg_sel=src, bank_data_in=temp B.
REQ-011 In IDLE and RESP, bank_en, bank_reg_sel and bank_data_in SHALL be 0.
REQ-012 bank_* outputs SHALL be decoded from state and latched registers only, never from live cmd_* inputs.
REQ-013 bank_en SHALL be high for exactly one cycle per write; LOAD/MOVE SHALL issue one write, SWAP two, READ none.
REQ-014 rsp_data SHALL be: LOAD imm; MOVE value moved; READ value read; SWAP original src value (temp A).
REQ-015 rsp_valid SHALL be 1 only in RESP, with rsp_data held stable until the rsp_ready handshake, after which state SHALL return to IDLE.
REQ-016 Latency from the accept edge to rsp_valid high SHALL be 2 edges for LOAD and READ, 3 for MOVE, and 5 for SWAP.
REQ-017 A new command SHALL NOT be accepted in the same cycle as a response handshake; cmd_ready SHALL rise the cycle after.
REQ-018 SWAP with src==dst SHALL complete normally and leave the register unchanged; MOVE with src==dst SHALL rewrite the same value.
REQ-019 rsp_ready high while not in RESP SHALL be ignored.

Reset
REQ-020 rst_n low SHALL immediately, without waiting for clk, force state to IDLE and drive cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, bank_en=0, bank_reg_sel=0, bank_data_in=0, and clear temps A/B.
REQ-021 While rst_n is low, cmd_ready SHALL be 0; after release, cmd_ready SHALL be 1 from the first clk edge.
REQ-022 Reset mid-operation SHALL abandon the command with no further bank writes; a SWAP interrupted after WR_A SHALL leave only dst updated.

Verification
REQ-023 Bench SHALL connect an 8x8 register_bank model and cover:
- LOAD dst=0 imm=AA, then LOAD dst=3 imm=55 -> each rsp_data = imm at 2-edge latency; READ src=0 -> AA; READ src=3 -> 55.
- MOVE src=3 dst=7 -> one bank_en pulse with sel=7, data=55; rsp_data=55; READ 7 -> 55.
- R1=12, R2=34, SWAP src=1 dst=2 -> rsp_data=12 at 5-edge latency; READ 1 -> 34; READ 2 -> 12.
- rsp_ready held low 4 cycles after MOVE -> rsp_valid and rsp_data stable; cmd_valid ignored with cmd_ready=0; no extra bank_en pulses.
- rst_n low asynchronously during SWAP WR_B -> all outputs 0 before the next edge; R(dst) updated, R(src) unchanged; next command accepted normally after release.
- SWAP src=dst=5 with R5=9C -> two writes of 9C; rsp_data=9C; R5=9C.
